// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares a single-port framebuffer RAM between VGA scanout, a pixel-writer
//   port and an internal clear engine. Scanout reads always win the RAM port;
//   clear writes come next, writer writes last. Each framebuffer word covers a
//   2^SCALE_LOG2 x 2^SCALE_LOG2 block of screen pixels. Pixel colour and syncs
//   leave through a two-stage pipeline (input at t appears at t+2).
//
// Ports
//   clk                      pixel clock (only clock)
//   btn_rst                  asynchronous active-low reset
//   pos_x, pos_y             screen position from the display timing block
//   rgb_en, h_sync, v_sync   active-video flag and syncs
//   wr_valid/wr_ready        writer handshake (wr_ready is combinational)
//   wr_addr, wr_data         writer address and RGB444 data
//   clr_start, clr_color     one-cycle clear request and fill colour
//   clr_busy, clr_done       clear running / one-cycle completion pulse
//   ram_en, ram_we           RAM enable / write enable
//   ram_addr, ram_wdata      RAM address / write data
//   ram_rdata                RAM read data, 1-cycle latency
//   pix_r, pix_g, pix_b      registered RGB444 pixel
//   hs_out, vs_out           syncs delayed to line up with the pixel

module vga_fb_arbiter #(
    parameter int unsigned FB_W       = 160,
    parameter int unsigned FB_H       = 120,
    parameter int unsigned SCALE_LOG2 = 2,
    parameter int unsigned AW         = 15
) (
    input  logic          clk,
    input  logic          btn_rst,
    input  logic [9:0]    pos_x,
    input  logic [9:0]    pos_y,
    input  logic          rgb_en,
    input  logic          h_sync,
    input  logic          v_sync,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [AW-1:0] wr_addr,
    input  logic [11:0]   wr_data,
    input  logic          clr_start,
    input  logic [11:0]   clr_color,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [11:0]   ram_wdata,
    input  logic [11:0]   ram_rdata,
    output logic [3:0]    pix_r,
    output logic [3:0]    pix_g,
    output logic [3:0]    pix_b,
    output logic          hs_out,
    output logic          vs_out
);

    localparam int unsigned   NPIX      = FB_W * FB_H;
    localparam logic [AW:0]   NPIX_W    = NPIX[AW:0];
    localparam logic [AW-1:0] LAST_ADDR = AW'(NPIX - 1);
    localparam int unsigned   SUB       = (1 << SCALE_LOG2) - 1;
    localparam logic [9:0]    SUB_MASK  = SUB[9:0];

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    state_t        state;
    logic          rst_meta;
    logic          rst_n;
    logic [AW-1:0] clr_addr;
    logic [11:0]   clr_color_q;

    logic          disp_req;
    logic [AW-1:0] fb_x;
    logic [AW-1:0] fb_y;
    logic [AW-1:0] disp_addr;
    logic          wr_in_range;

    logic          rgb_en_d1;
    logic          hs_d1;
    logic          vs_d1;
    logic          load_d1;
    logic [11:0]   hold;
    logic [11:0]   pix_next;

    // Reset asserts immediately, releases on the clock after two flops.
    always_ff @(posedge clk or negedge btn_rst) begin
        if (!btn_rst) begin
            rst_meta <= 1'b0;
            rst_n    <= 1'b0;
        end else begin
            rst_meta <= 1'b1;
            rst_n    <= rst_meta;
        end
    end

    // Constant multiply by FB_W; with FB_W=160 this reduces to (y<<7)+(y<<5).
    assign fb_x      = AW'(pos_x >> SCALE_LOG2);
    assign fb_y      = AW'(pos_y >> SCALE_LOG2);
    assign disp_addr = fb_y * AW'(FB_W) + fb_x;

    // One fetch per framebuffer word: only on the first sub-pixel of a block.
    assign disp_req    = rst_n && rgb_en && ((pos_x & SUB_MASK) == '0);
    assign wr_in_range = {1'b0, wr_addr} < NPIX_W;
    assign wr_ready    = rst_n && (state == IDLE) && !disp_req;

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (disp_req) begin
            ram_en   = 1'b1;
            ram_addr = disp_addr;
        end else if (rst_n && state == CLEAR) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = clr_addr;
            ram_wdata = clr_color_q;
        end else if (wr_valid && wr_ready && wr_in_range) begin
            ram_en    = 1'b1;
            ram_we    = 1'b1;
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            clr_addr    <= '0;
            clr_color_q <= '0;
            clr_busy    <= 1'b0;
            clr_done    <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state       <= CLEAR;
                        clr_color_q <= clr_color;
                        clr_addr    <= '0;
                        clr_busy    <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (!disp_req) begin
                        if (clr_addr == LAST_ADDR) begin
                            state    <= IDLE;
                            clr_addr <= '0;
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                        end else begin
                            clr_addr <= clr_addr + AW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_en_d1 <= 1'b0;
            hs_d1     <= 1'b0;
            vs_d1     <= 1'b0;
            load_d1   <= 1'b0;
        end else begin
            rgb_en_d1 <= rgb_en;
            hs_d1     <= h_sync;
            vs_d1     <= v_sync;
            load_d1   <= disp_req;
        end
    end

    // Between fetches the last fetched word is replayed from hold.
    always_comb begin
        pix_next = '0;
        if (rgb_en_d1) begin
            pix_next = load_d1 ? ram_rdata : hold;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold   <= '0;
            pix_r  <= '0;
            pix_g  <= '0;
            pix_b  <= '0;
            hs_out <= 1'b0;
            vs_out <= 1'b0;
        end else begin
            if (load_d1) begin
                hold <= ram_rdata;
            end
            pix_r  <= pix_next[11:8];
            pix_g  <= pix_next[7:4];
            pix_b  <= pix_next[3:0];
            hs_out <= hs_d1;
            vs_out <= vs_d1;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
//   Randomized bench for vga_fb_arbiter. A behavioural model (expected memory,
//   clear progress as a plain index, pixel pipeline as a queue) predicts every
//   output each cycle; a RAM model with 1-cycle read latency serves the DUT.

module tb_vga_fb_arbiter;

    localparam int unsigned FB_W       = 160;
    localparam int unsigned FB_H       = 120;
    localparam int unsigned SCALE_LOG2 = 2;
    localparam int unsigned AW         = 15;
    localparam int unsigned NPIX       = FB_W * FB_H;
    localparam int unsigned SC         = 1 << SCALE_LOG2;
    localparam int unsigned MEMSZ      = 1 << AW;

    logic          clk = 1'b0;
    logic          btn_rst = 1'b0;
    logic [9:0]    pos_x = '0, pos_y = '0;
    logic          rgb_en = 1'b0, h_sync = 1'b0, v_sync = 1'b0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [AW-1:0] wr_addr = '0;
    logic [11:0]   wr_data = '0;
    logic          clr_start = 1'b0;
    logic [11:0]   clr_color = '0;
    logic          clr_busy, clr_done;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [11:0]   ram_wdata;
    logic [11:0]   ram_rdata;
    logic [3:0]    pix_r, pix_g, pix_b;
    logic          hs_out, vs_out;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .FB_W(FB_W), .FB_H(FB_H), .SCALE_LOG2(SCALE_LOG2), .AW(AW)
    ) dut (
        .clk(clk), .btn_rst(btn_rst),
        .pos_x(pos_x), .pos_y(pos_y),
        .rgb_en(rgb_en), .h_sync(h_sync), .v_sync(v_sync),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_addr(wr_addr), .wr_data(wr_data),
        .clr_start(clr_start), .clr_color(clr_color),
        .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_en(ram_en), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .pix_r(pix_r), .pix_g(pix_g), .pix_b(pix_b),
        .hs_out(hs_out), .vs_out(vs_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // ---------------- RAM environment ----------------
    logic [11:0] ram [0:MEMSZ-1];
    logic [11:0] rd_q = '0;
    logic [11:0] junk = '0;
    logic        junk_en = 1'b0;
    bit          ram_loaded = 0;
    int          done_cnt = 0;
    int          f00_cnt = 0;

    assign ram_rdata = junk_en ? junk : rd_q;

    always @(posedge clk) begin
        junk <= 12'($urandom);
        if (!ram_loaded) begin
            for (int k = 0; k < MEMSZ; k++) ram[k] <= 12'(k);
            ram_loaded = 1;
        end else if (ram_en) begin
            if (ram_we) ram[ram_addr] <= ram_wdata;
            else        rd_q <= ram[ram_addr];
        end
        if (clr_done) done_cnt = done_cnt + 1;
        if (ram_en && ram_we && clr_busy && ram_wdata == 12'hF00) f00_cnt = f00_cnt + 1;
    end

    // ---------------- behavioural model + compare ----------------
    typedef struct {
        logic [11:0] pix;
        logic        hs;
        logic        vs;
    } pent_t;

    logic [11:0] exp_mem [0:MEMSZ-1];
    bit          mem_loaded = 0;
    bit          chk_en = 0;
    bit          m_clr = 0;
    int unsigned m_idx = 0;
    logic [11:0] m_color = '0;
    bit          m_done = 0;
    logic [11:0] m_hold = '0;
    pent_t       pq[$];

    always @(negedge clk) begin : cmp
        bit          disp;
        bit          wr_hit;
        int unsigned daddr;
        logic [11:0] cur;
        if (!mem_loaded) begin
            for (int k = 0; k < MEMSZ; k++) exp_mem[k] = 12'(k);
            mem_loaded = 1;
        end
        if (chk_en) begin
            disp   = rgb_en && (pos_x % SC == 0);
            daddr  = (pos_y / SC) * FB_W + pos_x / SC;
            wr_hit = wr_valid && !m_clr && !disp && (wr_addr < NPIX);

            chk("wr_ready", wr_ready, !m_clr && !disp);
            chk("clr_busy", clr_busy, m_clr);
            chk("clr_done", clr_done, m_done);
            if (disp) begin
                chk("ram_en", ram_en, 1);
                chk("ram_we", ram_we, 0);
                chk("ram_addr_rd", ram_addr, daddr);
            end else if (m_clr) begin
                chk("ram_en", ram_en, 1);
                chk("ram_we", ram_we, 1);
                chk("ram_addr_clr", ram_addr, m_idx);
                chk("ram_wdata_clr", ram_wdata, m_color);
            end else if (wr_hit) begin
                chk("ram_en", ram_en, 1);
                chk("ram_we", ram_we, 1);
                chk("ram_addr_wr", ram_addr, wr_addr);
                chk("ram_wdata_wr", ram_wdata, wr_data);
            end else begin
                chk("ram_en_idle", ram_en, 0);
            end

            if (disp) m_hold = exp_mem[daddr];
            cur = rgb_en ? m_hold : 12'h000;
            pq.push_back('{cur, h_sync, v_sync});
            if (pq.size() == 3) begin
                chk("pix", {pix_r, pix_g, pix_b}, pq[0].pix);
                chk("hs_out", hs_out, pq[0].hs);
                chk("vs_out", vs_out, pq[0].vs);
                void'(pq.pop_front());
            end

            if (!disp && m_clr) exp_mem[m_idx] = m_color;
            else if (wr_hit)    exp_mem[wr_addr] = wr_data;

            m_done = 0;
            if (m_clr) begin
                if (!disp) begin
                    m_idx++;
                    if (m_idx == NPIX) begin
                        m_clr  = 0;
                        m_done = 1;
                    end
                end
            end else if (clr_start) begin
                m_clr   = 1;
                m_idx   = 0;
                m_color = clr_color;
            end
        end
    end

    // ---------------- stimulus ----------------
    bit fired = 0;
    bit vid_on = 0;
    bit wr_on = 0;
    int unsigned lc = 200, xbase = 0, ybase = 0;
    bit vs_line = 0;

    task automatic step();
        @(negedge clk);
        fired = wr_valid && wr_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_cycle();
        if (vid_on) begin
            if (lc >= 200) begin
                lc      = 0;
                xbase   = $urandom_range(0, 479);
                ybase   = $urandom_range(0, 479);
                vs_line = ($urandom % 8 == 0);
            end
            pos_x  = 10'(xbase + lc);
            pos_y  = 10'(ybase);
            rgb_en = (lc < 160);
            h_sync = (lc >= 170 && lc < 186);
            v_sync = vs_line;
            lc++;
        end else begin
            pos_x  = 10'($urandom);
            pos_y  = 10'($urandom);
            rgb_en = 1'b0;
            h_sync = 1'($urandom);
            v_sync = 1'($urandom);
        end
        if (!wr_valid || fired) begin
            if (wr_on && ($urandom % 4 != 0)) begin
                wr_valid = 1'b1;
                wr_addr  = ($urandom % 8 == 0) ? AW'(NPIX + $urandom % (MEMSZ - NPIX))
                                               : AW'($urandom % NPIX);
                wr_data  = 12'($urandom);
            end else begin
                wr_valid = 1'b0;
            end
        end
        step();
        clr_start = 1'b0;
    endtask

    task automatic drain();
        int n;
        wr_on  = 0;
        vid_on = 0;
        n = 0;
        while (wr_valid && n < 100) begin
            gen_cycle();
            n++;
        end
        chk("drain", wr_valid, 0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_wr_ready"}, wr_ready, 0);
        chk({tag, "_ram_en"}, ram_en, 0);
        chk({tag, "_ram_we"}, ram_we, 0);
        chk({tag, "_clr_busy"}, clr_busy, 0);
        chk({tag, "_clr_done"}, clr_done, 0);
        chk({tag, "_pix"}, {pix_r, pix_g, pix_b}, 0);
        chk({tag, "_syncs"}, {hs_out, vs_out}, 0);
    endtask

    logic [11:0] got [0:17];
    int          n;
    int          done_before;
    int          nbad;

    initial begin
        // reset, with video inputs active to show nothing leaks out
        rgb_en = 1'b1;
        #12;
        check_all_zero("reset");
        rgb_en = 1'b0;
        #11 btn_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1;

        // directed scanout of preloaded words
        for (int i = 0; i < 18; i++) begin
            pos_x  = 10'(i);
            pos_y  = 10'd0;
            rgb_en = (i < 16);
            h_sync = 1'($urandom);
            v_sync = 1'($urandom);
            step();
            got[i] = {pix_r, pix_g, pix_b};
        end
        for (int i = 9; i <= 12; i++) chk("scan_y0_x8_11", got[i], 12'h002);
        chk("scan_y0_x12", got[13], 12'h003);
        pos_x = 10'd8; pos_y = 10'd4; rgb_en = 1'b1;
        step();
        pos_x = 10'd9;
        step();
        chk("scan_y4_x8", {pix_r, pix_g, pix_b}, 12'h0A2);
        rgb_en = 1'b0;
        step();

        // randomized video + writer traffic
        vid_on = 1; wr_on = 1;
        repeat (3000) gen_cycle();

        // pure blanking with garbage on the read bus
        vid_on = 0;
        repeat (2) gen_cycle();
        junk_en = 1'b1;
        repeat (300) gen_cycle();
        junk_en = 1'b0;
        repeat (2) gen_cycle();

        // out-of-range write: accepted, no RAM access
        drain();
        rgb_en = 1'b0; wr_valid = 1'b1; wr_addr = AW'(NPIX); wr_data = 12'hABC;
        @(negedge clk);
        chk("oor_wr_ready", wr_ready, 1);
        chk("oor_ram_en", ram_en, 0);
        @(posedge clk); #1;
        wr_valid = 1'b0;

        // clear start coincident with a writer transfer
        wr_valid = 1'b1; wr_addr = AW'(77); wr_data = 12'h123;
        clr_start = 1'b1; clr_color = 12'hF00;
        @(negedge clk);
        chk("coinc_wr_ready", wr_ready, 1);
        chk("coinc_ram_addr", ram_addr, 77);
        chk("coinc_ram_wdata", ram_wdata, 12'h123);
        @(posedge clk); #1;
        wr_valid = 1'b0; clr_start = 1'b0; fired = 0;
        chk("clr1_busy_rise", clr_busy, 1);

        vid_on = 1; wr_on = 1;
        n = 0;
        while (done_cnt == 0 && n < 40000) begin
            if (n == 1000) begin
                clr_color = 12'h0FF;
                clr_start = 1'b1;
            end
            gen_cycle();
            n++;
        end
        repeat (3) gen_cycle();
        chk("clr1_done_cnt", done_cnt, 1);
        chk("clr1_write_cnt", f00_cnt, NPIX);
        chk("clr1_busy_after", clr_busy, 0);

        // clear aborted by reset around address 5000
        drain();
        vid_on = 1;
        clr_color = 12'h0F0; clr_start = 1'b1;
        gen_cycle();
        n = 0;
        while (m_idx < 5000 && n < 12000) begin
            gen_cycle();
            n++;
        end
        chk("abort_busy_before", clr_busy, 1);
        done_before = done_cnt;
        chk_en = 0;
        rgb_en = 1'b1; pos_x = '0; wr_valid = 1'b0; clr_start = 1'b0;
        #2 btn_rst = 1'b0;
        #1;
        check_all_zero("abort");
        rgb_en = 1'b0;
        repeat (3) @(posedge clk);
        #3 btn_rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        m_clr = 0; m_done = 0; m_hold = '0; pq.delete(); fired = 0;
        chk_en = 1;
        chk("abort_busy_after", clr_busy, 0);
        chk("abort_no_done", done_cnt, done_before);

        // full clear again from address 0, in blanking
        vid_on = 0;
        clr_color = 12'h00F; clr_start = 1'b1;
        gen_cycle();
        n = 0;
        while (done_cnt == done_before && n < 25000) begin
            gen_cycle();
            n++;
        end
        repeat (3) gen_cycle();
        chk("clr2_done_cnt", done_cnt, done_before + 1);

        nbad = 0;
        for (int k = 0; k < MEMSZ; k++) if (ram[k] !== exp_mem[k]) nbad++;
        chk("ram_contents", nbad, 0);
        chk("ram_first", ram[0], 12'h00F);
        chk("ram_last", ram[NPIX-1], 12'h00F);
        chk("ram_beyond", ram[NPIX], 12'hB00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
